ps2_mouse_ctrl: RTL and testbench



---
 rtl/ps2_pkg.sv | 19 +
 rtl/ps2_mouse_ctrl_if.sv | 12 +
 rtl/ps2_rx_frame.sv | 61 ++++++
 rtl/ps2_mouse_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_ps2_mouse_ctrl.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 mouse host controller.
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_INHIBIT,
      ST_TX,
      ST_WAIT_ACK,
      ST_STREAM
   } ps2_state_e;

   localparam int unsigned FRAME_BITS   = 11;
   localparam logic [7:0]  CMD_BYTE_DEF = 8'hF4;
   localparam logic [7:0]  ACK_BYTE_DEF = 8'hFA;

   function automatic logic odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/ps2_mouse_ctrl_if.sv
// Register-window bus and event pulses of the PS/2 mouse controller.
interface ps2_mouse_ctrl_if;
   logic       io_cs;
   logic [1:0] addr;
   logic [7:0] data;
   logic       TCP;
   logic       r_ack;
   logic       dav;

   modport slave (input io_cs, addr, output data, TCP, r_ack, dav);
   modport master (output io_cs, addr, input data, TCP, r_ack, dav);
endinterface

// File: rtl/ps2_rx_frame.sv
// Device-to-host PS/2 frame receiver: shift register, frame checks, timeout.
module ps2_rx_frame
   import ps2_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 20000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       fall,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       rx_err
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [3:0]    bit_cnt;
   logic [9:0]    sr;
   logic [TW-1:0] tmo;
   logic          frame_end;
   logic          good;
   logic          timeout;

   // The stop bit is judged straight off the line on its own edge, so the
   // verdict is available in the same cycle as the final falling edge.
   always_comb begin
      frame_end = fall && (bit_cnt == 4'(FRAME_BITS - 1));
      good      = frame_end && !sr[0] && ps2_data && (^sr[9:1]);
      timeout   = (bit_cnt != 4'd0) && ps2_clk && (tmo == TW'(TIMEOUT_CYCLES - 1));
      rx_valid  = en && good;
      rx_err    = en && ((frame_end && !good) || timeout);
      rx_byte   = sr[8:1];
   end

   always_ff @(posedge clk) begin
      if (rst || !en) begin
         bit_cnt <= '0;
         sr      <= '0;
         tmo     <= '0;
      end else if (timeout) begin
         bit_cnt <= '0;
         tmo     <= '0;
      end else if (fall) begin
         tmo <= '0;
         if (frame_end) begin
            bit_cnt <= '0;
         end else begin
            bit_cnt <= bit_cnt + 4'd1;
            sr      <= {ps2_data, sr[9:1]};
         end
      end else if ((bit_cnt != 4'd0) && ps2_clk) begin
         tmo <= tmo + 1'b1;
      end else begin
         tmo <= '0;
      end
   end

endmodule

// File: rtl/ps2_mouse_ctrl.sv
// PS/2 mouse host: enables reporting after reset, then latches 3-byte packets
// into a read-only register window.
module ps2_mouse_ctrl
   import ps2_pkg::*;
#(
   parameter int unsigned INHIBIT_CYCLES = 10000,
   parameter logic [7:0]  CMD_BYTE       = CMD_BYTE_DEF,
   parameter logic [7:0]  ACK_BYTE       = ACK_BYTE_DEF,
   parameter int unsigned TIMEOUT_CYCLES = 20000
) (
   input  logic            clk,
   input  logic            rst,
   ps2_mouse_ctrl_if.slave bus,
   output logic            t_clk,
   output logic            t_data,
   inout  wire             MOUSE_CLOCK,
   inout  wire             MOUSE_DATA
);

   localparam int unsigned IW = $clog2(INHIBIT_CYCLES + 1);

   ps2_state_e    state, state_n;
   logic [IW-1:0] inh_cnt, inh_cnt_n;
   logic [3:0]    tx_cnt, tx_cnt_n;
   logic [1:0]    pkt_idx, pkt_idx_n;
   logic [2:0]    b0, b0_n, status_q, status_n;
   logic [7:0]    b1, b1_n, x_q, x_n, y_q, y_n;
   logic          t_clk_n, t_data_n;
   logic          tcp_q, tcp_n, rack_q, rack_n, dav_q, dav_n;
   logic [1:0]    clk_sync, data_sync;
   logic          clk_prev, fall, rx_en;
   logic [7:0]    rx_byte;
   logic          rx_valid, rx_err;
   logic          unused_io_cs;

   assign MOUSE_CLOCK  = t_clk  ? 1'b0 : 1'bz;
   assign MOUSE_DATA   = t_data ? 1'b0 : 1'bz;
   assign unused_io_cs = bus.io_cs;

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sync  <= '1;
         data_sync <= '1;
         clk_prev  <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[0], MOUSE_CLOCK};
         data_sync <= {data_sync[0], MOUSE_DATA};
         clk_prev  <= clk_sync[1];
      end
   end

   assign fall  = clk_prev && !clk_sync[1];
   assign rx_en = (state == ST_WAIT_ACK) || (state == ST_STREAM);

   ps2_rx_frame #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
      .clk      (clk),
      .rst      (rst),
      .en       (rx_en),
      .ps2_clk  (clk_sync[1]),
      .ps2_data (data_sync[1]),
      .fall     (fall),
      .rx_byte  (rx_byte),
      .rx_valid (rx_valid),
      .rx_err   (rx_err)
   );

   always_comb begin
      state_n   = state;
      inh_cnt_n = inh_cnt;
      tx_cnt_n  = tx_cnt;
      pkt_idx_n = pkt_idx;
      b0_n      = b0;
      b1_n      = b1;
      status_n  = status_q;
      x_n       = x_q;
      y_n       = y_q;
      t_clk_n   = t_clk;
      t_data_n  = t_data;
      tcp_n     = 1'b0;
      rack_n    = 1'b0;
      dav_n     = 1'b0;
      case (state)
         ST_INHIBIT: begin
            t_clk_n  = 1'b1;
            t_data_n = 1'b0;
            if (inh_cnt == IW'(INHIBIT_CYCLES)) begin
               t_data_n = 1'b1;
               tx_cnt_n = '0;
               state_n  = ST_TX;
            end else begin
               inh_cnt_n = inh_cnt + 1'b1;
            end
         end
         // Edges 1-8 data, 9 parity, 10 stop release, 11 device ack, 12 done.
         ST_TX: begin
            t_clk_n = 1'b0;
            if (fall) begin
               tx_cnt_n = tx_cnt + 4'd1;
               if (tx_cnt < 4'd8)       t_data_n = ~CMD_BYTE[tx_cnt[2:0]];
               else if (tx_cnt == 4'd8) t_data_n = ~odd_parity(CMD_BYTE);
               else if (tx_cnt == 4'd9) t_data_n = 1'b0;
               else if (tx_cnt == 4'd11) begin
                  tcp_n   = 1'b1;
                  state_n = ST_WAIT_ACK;
               end
            end
         end
         ST_WAIT_ACK: begin
            if (rx_valid && (rx_byte == ACK_BYTE)) begin
               rack_n    = 1'b1;
               pkt_idx_n = '0;
               state_n   = ST_STREAM;
            end
         end
         ST_STREAM: begin
            if (rx_err) begin
               pkt_idx_n = '0;
            end else if (rx_valid) begin
               case (pkt_idx)
                  2'd0: begin b0_n = rx_byte[2:0]; pkt_idx_n = 2'd1; end
                  2'd1: begin b1_n = rx_byte;      pkt_idx_n = 2'd2; end
                  2'd2: begin
                     status_n  = b0;
                     x_n       = b1;
                     y_n       = rx_byte;
                     dav_n     = 1'b1;
                     pkt_idx_n = 2'd0;
                  end
                  default: pkt_idx_n = 2'd0;
               endcase
            end
         end
         default: state_n = ST_INHIBIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_INHIBIT;
         inh_cnt  <= '0;
         tx_cnt   <= '0;
         pkt_idx  <= '0;
         b0       <= '0;
         b1       <= '0;
         status_q <= '0;
         x_q      <= '0;
         y_q      <= '0;
         t_clk    <= 1'b0;
         t_data   <= 1'b0;
         tcp_q    <= 1'b0;
         rack_q   <= 1'b0;
         dav_q    <= 1'b0;
      end else begin
         state    <= state_n;
         inh_cnt  <= inh_cnt_n;
         tx_cnt   <= tx_cnt_n;
         pkt_idx  <= pkt_idx_n;
         b0       <= b0_n;
         b1       <= b1_n;
         status_q <= status_n;
         x_q      <= x_n;
         y_q      <= y_n;
         t_clk    <= t_clk_n;
         t_data   <= t_data_n;
         tcp_q    <= tcp_n;
         rack_q   <= rack_n;
         dav_q    <= dav_n;
      end
   end

   assign bus.TCP   = tcp_q;
   assign bus.r_ack = rack_q;
   assign bus.dav   = dav_q;

   always_comb begin
      bus.data = 8'h00;
      case (bus.addr)
         2'b00:   bus.data = {5'b0, status_q};
         2'b01:   bus.data = x_q;
         2'b10:   bus.data = y_q;
         default: bus.data = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// Scoreboard bench: a PS/2 device model drives random frames, a packet-level
// model predicts events, and a monitor checks every pulse and register read.
module tb_ps2_mouse_ctrl;

   localparam int unsigned INH = 20;
   localparam int unsigned TMO = 200;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic t_clk, t_data;
   wire  ms_clk, ms_data;
   logic dev_clk_low  = 1'b0;
   logic dev_data_low = 1'b0;

   pullup (ms_clk);
   pullup (ms_data);
   assign ms_clk  = dev_clk_low  ? 1'b0 : 1'bz;
   assign ms_data = dev_data_low ? 1'b0 : 1'bz;

   ps2_mouse_ctrl_if bus ();

   ps2_mouse_ctrl #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .t_clk       (t_clk),
      .t_data      (t_data),
      .MOUSE_CLOCK (ms_clk),
      .MOUSE_DATA  (ms_data)
   );

   always #5 clk = ~clk;

   typedef enum int {EV_TCP, EV_ACK, EV_DAV} ev_kind_e;
   typedef struct {
      ev_kind_e   kind;
      logic [7:0] st, x, y;
   } ev_t;

   ev_t        exp_q[$];
   int         tests = 0;
   int         fails = 0;
   logic [7:0] m_st = 8'h00, m_x = 8'h00, m_y = 8'h00;
   bit         in_stream = 1'b0;
   int         idx = 0;
   logic [7:0] pkt[3];
   bit         rd_req = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_ev(input ev_kind_e k, input logic [7:0] st, input logic [7:0] x, input logic [7:0] y);
      ev_t e;
      e.kind = k; e.st = st; e.x = x; e.y = y;
      exp_q.push_back(e);
   endtask

   task automatic read_all(input logic [7:0] st, input logic [7:0] x, input logic [7:0] y);
      logic [7:0] exp;
      for (int a = 0; a < 4; a++) begin
         bus.addr = 2'(a);
         #1;
         exp = (a == 0) ? st : (a == 1) ? x : (a == 2) ? y : 8'h00;
         check($sformatf("read addr%0d", a), 32'(bus.data), 32'(exp));
      end
   endtask

   task automatic pulse_seen(input ev_kind_e k, input string name);
      ev_t e;
      if (exp_q.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL unexpected %s pulse: got 1 expected 0 at %0t", name, $time);
      end else begin
         e = exp_q.pop_front();
         check({"event order ", name}, 32'(e.kind), 32'(k));
         if (k == EV_DAV && e.kind == EV_DAV) read_all(e.st, e.x, e.y);
      end
   endtask

   // Monitor: consumes expected events as the DUT presents pulses.
   always @(negedge clk) begin
      if (rd_req) begin
         if (rst) begin
            check("reset t_clk", 32'(t_clk), 32'd0);
            check("reset t_data", 32'(t_data), 32'd0);
            check("reset pulses", 32'({bus.TCP, bus.r_ack, bus.dav}), 32'd0);
         end
         read_all(m_st, m_x, m_y);
         rd_req = 1'b0;
      end else if (!rst) begin
         if (bus.TCP   === 1'b1) pulse_seen(EV_TCP, "TCP");
         if (bus.r_ack === 1'b1) pulse_seen(EV_ACK, "r_ack");
         if (bus.dav   === 1'b1) pulse_seen(EV_DAV, "dav");
      end
   end

   // Packet-level reference: what a correct host does with each received byte.
   task automatic model_byte(input logic [7:0] b, input bit ok);
      if (!in_stream) begin
         if (ok && b == 8'hFA) begin
            push_ev(EV_ACK, 8'h00, 8'h00, 8'h00);
            in_stream = 1'b1;
            idx = 0;
         end
      end else if (!ok) begin
         idx = 0;
      end else begin
         pkt[idx] = b;
         idx++;
         if (idx == 3) begin
            m_st = {5'b0, pkt[0][2:0]};
            m_x  = pkt[1];
            m_y  = pkt[2];
            push_ev(EV_DAV, m_st, m_x, m_y);
            idx = 0;
         end
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_raw(input logic [10:0] f, input int n);
      for (int k = 0; k < n; k++) begin
         dev_data_low = ~f[k];
         tick(3);
         dev_clk_low = 1'b1;
         tick(3);
         dev_clk_low = 1'b0;
      end
      dev_data_low = 1'b0;
   endtask

   // kind: 0 good, 1 bad parity, 2 bad stop, 3 truncated (timeout)
   task automatic send_frame(input logic [7:0] b, input int kind);
      logic [10:0] f;
      f[0]    = 1'b0;
      f[8:1]  = b;
      f[9]    = (~^b) ^ (kind == 1);
      f[10]   = (kind != 2);
      model_byte(b, kind == 0);
      if (kind == 3) begin
         send_raw(f, 1 + int'($urandom_range(1, 8)));
         tick(TMO + 60);
      end else begin
         send_raw(f, 11);
         tick(12);
      end
   endtask

   task automatic send_packet(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      send_frame(a, 0);
      send_frame(b, 0);
      send_frame(c, 0);
   endtask

   task automatic request_read();
      rd_req = 1'b1;
      tick(2);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      dev_clk_low = 1'b0;
      dev_data_low = 1'b0;
      in_stream = 1'b0;
      idx = 0;
      m_st = 8'h00; m_x = 8'h00; m_y = 8'h00;
      tick(2);
      rd_req = 1'b1;
      tick(3);
      rst = 1'b0;
   endtask

   task automatic startup();
      int n, guard;
      logic [9:0] bits;
      n = 0;
      guard = 0;
      while (t_data !== 1'b1 && guard < 500) begin
         @(negedge clk);
         if (t_clk === 1'b1 && t_data === 1'b0) n++;
         guard++;
      end
      check("inhibit cycles", 32'(n), 32'(INH));
      check("start bit driven", 32'(t_data), 32'd1);
      guard = 0;
      while (ms_clk !== 1'b1 && guard < 50) begin
         tick(1);
         guard++;
      end
      check("clock released", 32'(ms_clk), 32'd1);
      check("start bit on line", 32'(ms_data), 32'd0);
      push_ev(EV_TCP, 8'h00, 8'h00, 8'h00);
      bits = '0;
      for (int i = 0; i < 12; i++) begin
         tick(3);
         if (i >= 1 && i <= 10) bits[i-1] = ms_data;
         if (i == 10) dev_data_low = 1'b1;
         dev_clk_low = 1'b1;
         tick(3);
         dev_clk_low = 1'b0;
      end
      dev_data_low = 1'b0;
      check("command byte", 32'(bits[7:0]), 32'hF4);
      check("command parity", 32'(bits[8]), 32'd0);
      check("command stop", 32'(bits[9]), 32'd1);
      tick(10);
   endtask

   initial begin
      logic [7:0] b;
      int kind;
      bus.io_cs = 1'b0;
      bus.addr  = 2'b00;

      do_reset();
      startup();
      do b = 8'($urandom); while (b == 8'hFA);
      send_frame(b, 0);
      send_frame(8'hFA, 0);

      send_packet(8'hAB, 8'hBC, 8'hCD);
      send_packet(8'hCD, 8'hBC, 8'hAB);

      send_frame(8'hAB, 0);
      send_frame(8'h5A, 1);
      request_read();
      send_packet(8'($urandom), 8'($urandom), 8'($urandom));

      send_frame(8'h07, 0);
      send_frame(8'h11, 3);
      request_read();
      send_packet(8'($urandom), 8'($urandom), 8'($urandom));

      for (int p = 0; p < 16; p++) begin
         for (int j = 0; j < 3; j++) begin
            kind = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0;
            send_frame(8'($urandom), kind);
         end
      end
      request_read();

      send_frame(8'h3C, 0);
      send_raw({1'b1, 1'b0, 8'h99, 1'b0}, 5);
      do_reset();
      startup();
      send_frame(8'hFA, 0);
      send_packet(8'($urandom), 8'($urandom), 8'($urandom));

      tick(30);
      check("pending events", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
